// File: rtl/tm_entry_ctl.sv
// Test-mode entry controller: a TST rise opens a serial key + mode window on SCL/SDA, and the test modes assert only when it completes.
// Latency: pad edges take effect SYNC_STG+1 clocks after they reach the pins; all outputs are registered.
// Backpressure: none; SCL strobes outside KEY/MODE are ignored, and a stalled SCL times out into LOCK.
module tm_entry_ctl #(
    parameter int unsigned       KEY_W    = 16,
    parameter logic [KEY_W-1:0]  KEY      = 16'hA55A,
    parameter int unsigned       MODE_W   = 3,
    parameter int unsigned       TO_W     = 12,
    parameter int unsigned       SYNC_STG = 2      // must be at least 2
) (
    input  logic              clk,
    input  logic              rstz,
    input  logic              i_tst,
    input  logic              i_scl,
    input  logic              i_sda,
    output logic [MODE_W-1:0] o_test_mode,
    output logic              o_atpg_mode,
    output logic              o_busy,
    output logic              o_key_err
);

    // The shifter keeps only the bits before the current one; the newest bit is
    // always sda_s itself, so the oldest stored bit would never be read.
    localparam int unsigned      SH_W      = (KEY_W > MODE_W) ? KEY_W : MODE_W;
    localparam int unsigned      CNT_W     = $clog2(SH_W + 1);
    localparam logic [CNT_W-1:0] KEY_LAST  = CNT_W'(KEY_W - 1);
    localparam logic [CNT_W-1:0] MODE_LAST = CNT_W'(MODE_W - 1);
    localparam logic [MODE_W-1:0] MODE_ATPG = MODE_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEY,
        ST_MODE,
        ST_ARMED,
        ST_LOCK
    } state_t;

    logic [SYNC_STG-1:0] tst_sync_q, tst_sync_d;
    logic [SYNC_STG-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STG-1:0] sda_sync_q, sda_sync_d;
    logic                tst_dly_q, tst_dly_d;
    logic                scl_dly_q, scl_dly_d;

    state_t              state_q, state_d;
    logic [SH_W-2:0]     shift_q, shift_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic [MODE_W-1:0]   mode_q, mode_d;
    logic                atpg_q, atpg_d;
    logic                busy_q, busy_d;
    logic                key_err_q, key_err_d;

    logic                tst_s, scl_s, sda_s;
    logic                tst_rise, tst_fall, scl_rise;
    logic [KEY_W-1:0]    key_word;
    logic [MODE_W-1:0]   mode_word;

    assign tst_s    = tst_sync_q[SYNC_STG-1];
    assign scl_s    = scl_sync_q[SYNC_STG-1];
    assign sda_s    = sda_sync_q[SYNC_STG-1];
    assign tst_rise = tst_s & ~tst_dly_q;
    assign tst_fall = ~tst_s & tst_dly_q;
    assign scl_rise = scl_s & ~scl_dly_q;

    // Candidate words as they stand once the bit arriving this cycle is appended.
    assign key_word  = {shift_q[KEY_W-2:0], sda_s};
    assign mode_word = {shift_q[MODE_W-2:0], sda_s};

    // Pad synchronizer chains plus one extra stage for edge detection.
    always_comb begin
        tst_sync_d = {tst_sync_q[SYNC_STG-2:0], i_tst};
        scl_sync_d = {scl_sync_q[SYNC_STG-2:0], i_scl};
        sda_sync_d = {sda_sync_q[SYNC_STG-2:0], i_sda};
        tst_dly_d  = tst_s;
        scl_dly_d  = scl_s;
    end

    // Entry sequence: next state, key/mode shifting, timeout and output values.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        to_cnt_d  = '0;
        mode_d    = mode_q;
        key_err_d = key_err_q;

        case (state_q)
            ST_IDLE: begin
                if (tst_rise) begin
                    state_d   = ST_KEY;
                    shift_d   = '0;
                    bit_cnt_d = '0;
                    key_err_d = 1'b0;
                end
            end
            ST_KEY, ST_MODE: begin
                to_cnt_d = to_cnt_q + TO_W'(1);
                if (tst_fall) begin
                    // Tester abort: a bit strobed in the same cycle is dropped.
                    state_d = ST_IDLE;
                end else if (scl_rise) begin
                    to_cnt_d  = '0;
                    shift_d   = {shift_q[SH_W-3:0], sda_s};
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (state_q == ST_KEY && bit_cnt_q == KEY_LAST) begin
                        if (key_word == KEY) begin
                            state_d   = ST_MODE;
                            shift_d   = '0;
                            bit_cnt_d = '0;
                        end else begin
                            state_d   = ST_LOCK;
                            key_err_d = 1'b1;
                        end
                    end else if (state_q == ST_MODE && bit_cnt_q == MODE_LAST) begin
                        state_d = ST_ARMED;
                        mode_d  = mode_word;
                    end
                end else if (to_cnt_q == {TO_W{1'b1}}) begin
                    state_d   = ST_LOCK;
                    key_err_d = 1'b1;
                end
            end
            ST_ARMED: begin
                if (tst_fall) begin
                    state_d = ST_IDLE;
                    mode_d  = '0;
                end
            end
            ST_LOCK: begin
                if (tst_fall) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                mode_d  = '0;
            end
        endcase

        // The timeout only runs while a sequence is in progress.
        if (state_d != ST_KEY && state_d != ST_MODE) begin
            to_cnt_d = '0;
        end

        busy_d = (state_d == ST_KEY) || (state_d == ST_MODE);
        atpg_d = (state_d == ST_ARMED) && (mode_d == MODE_ATPG);
    end

    // State and output registers; reset drops test mode immediately.
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            tst_sync_q <= '0;
            scl_sync_q <= '0;
            sda_sync_q <= '0;
            tst_dly_q  <= 1'b0;
            scl_dly_q  <= 1'b0;
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            to_cnt_q   <= '0;
            mode_q     <= '0;
            atpg_q     <= 1'b0;
            busy_q     <= 1'b0;
            key_err_q  <= 1'b0;
        end else begin
            tst_sync_q <= tst_sync_d;
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            tst_dly_q  <= tst_dly_d;
            scl_dly_q  <= scl_dly_d;
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            to_cnt_q   <= to_cnt_d;
            mode_q     <= mode_d;
            atpg_q     <= atpg_d;
            busy_q     <= busy_d;
            key_err_q  <= key_err_d;
        end
    end

    assign o_test_mode = mode_q;
    assign o_atpg_mode = atpg_q;
    assign o_busy      = busy_q;
    assign o_key_err   = key_err_q;

endmodule
